// File: rtl/vram_arbiter_pkg.sv
// Shared defaults and slot-owner encoding for the VRAM arbiter.
package vram_arbiter_pkg;

  localparam int unsigned FB_W_DEFAULT     = 160;
  localparam int unsigned FB_H_DEFAULT     = 120;
  localparam int unsigned SCALE_SH_DEFAULT = 2;
  localparam int unsigned ADDR_W_DEFAULT   = 15;
  localparam int unsigned DATA_W_DEFAULT   = 8;

  // Width of the pixel coordinates coming from the timing generator.
  localparam int unsigned POS_W = 10;

  // Which agent owns the VRAM port in a given cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_DISP = 2'd1,
    SLOT_M0   = 2'd2,
    SLOT_M1   = 2'd3
  } slot_t;

endpackage

// File: rtl/vram_arbiter_addr_gen.sv
// Texel address generator: screen position -> linear texel address via
// shift-add (no multiplier), plus a framebuffer range check on a second
// address so master accesses can be qualified with the same logic.
module fb_addr_gen
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned FB_W     = FB_W_DEFAULT,
  parameter int unsigned FB_H     = FB_H_DEFAULT,
  parameter int unsigned SCALE_SH = SCALE_SH_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic [POS_W-1:0]  x_pos,
  input  logic [POS_W-1:0]  y_pos,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic [ADDR_W-1:0] texel_addr,
  output logic              chk_in_range
);

  localparam int unsigned FB_TEXELS = FB_W * FB_H;
  localparam logic [31:0] FB_W_BITS = 32'(FB_W);

  logic [POS_W-1:0] col;
  logic [POS_W-1:0] row;

  assign col = x_pos >> SCALE_SH;
  assign row = y_pos >> SCALE_SH;

  // row*FB_W unrolled into one shifted add per set bit of the constant width
  always_comb begin
    texel_addr = ADDR_W'(col);
    for (int unsigned i = 0; i < 32; i++) begin
      if (FB_W_BITS[i]) begin
        texel_addr = texel_addr + (ADDR_W'(row) << i);
      end
    end
  end

  // Addresses past the last texel are granted but must not touch the RAM
  assign chk_in_range = (32'(chk_addr) < FB_TEXELS);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: a display fetch slot every fourth active pixel,
// all remaining cycles shared round-robin between two masters.
// Optional build macro VRAM_ARB_STATS_EN adds per-master stall counters.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned FB_W     = FB_W_DEFAULT,
  parameter int unsigned FB_H     = FB_H_DEFAULT,
  parameter int unsigned SCALE_SH = SCALE_SH_DEFAULT,
  parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W   = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              display_on,
  input  logic [POS_W-1:0]  x_pos,
  input  logic [POS_W-1:0]  y_pos,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       m0_stall_cnt,
  output logic [15:0]       m1_stall_cnt
`endif
);

  slot_t             owner_c;
  logic              disp_slot_c;
  logic              rr_ptr;          // 1: m1 has priority on the next tie
  logic [ADDR_W-1:0] sel_addr_c;
  logic [ADDR_W-1:0] disp_addr_c;
  logic              in_range_c;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_oor_q;
  logic              disp_d1;
  logic              don_d1;

  assign disp_slot_c = display_on && (x_pos[1:0] == 2'b00);
  assign sel_addr_c  = (owner_c == SLOT_M1) ? m1_addr : m0_addr;

  fb_addr_gen #(
    .FB_W     (FB_W),
    .FB_H     (FB_H),
    .SCALE_SH (SCALE_SH),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .chk_addr     (sel_addr_c),
    .texel_addr   (disp_addr_c),
    .chk_in_range (in_range_c)
  );

  // Slot owner: reset idles the port, display beats masters, ties round-robin
  always_comb begin
    owner_c = SLOT_IDLE;
    if (!rst_n) begin
      owner_c = SLOT_IDLE;
    end else if (disp_slot_c) begin
      owner_c = SLOT_DISP;
    end else if (m0_req && m1_req) begin
      owner_c = rr_ptr ? SLOT_M1 : SLOT_M0;
    end else if (m0_req) begin
      owner_c = SLOT_M0;
    end else if (m1_req) begin
      owner_c = SLOT_M1;
    end
  end

  // Drive the RAM port and grants for the owner; idle cycles replay the last address/data
  always_comb begin
    vram_addr  = addr_q;
    vram_wdata = wdata_q;
    vram_we    = 1'b0;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    case (owner_c)
      SLOT_DISP: vram_addr = disp_addr_c;
      SLOT_M0: begin
        m0_gnt     = 1'b1;
        vram_addr  = m0_addr;
        vram_wdata = m0_wdata;
        vram_we    = m0_we && in_range_c;
      end
      SLOT_M1: begin
        m1_gnt     = 1'b1;
        vram_addr  = m1_addr;
        vram_wdata = m1_wdata;
        vram_we    = m1_we && in_range_c;
      end
      default: ;
    endcase
  end

  // Round-robin pointer, read-return flags and last-driven RAM port values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rd_oor_q  <= 1'b0;
    end else begin
      addr_q    <= vram_addr;
      wdata_q   <= vram_wdata;
      if (owner_c == SLOT_M0) begin
        rr_ptr <= 1'b1;
      end else if (owner_c == SLOT_M1) begin
        rr_ptr <= 1'b0;
      end
      m0_rvalid <= (owner_c == SLOT_M0) && !m0_we;
      m1_rvalid <= (owner_c == SLOT_M1) && !m1_we;
      rd_oor_q  <= !in_range_c;
    end
  end

  // Read data comes straight off the RAM in the rvalid cycle; out-of-range reads return 0
  assign m0_rdata = (m0_rvalid && !rd_oor_q) ? vram_rdata : '0;
  assign m1_rdata = (m1_rvalid && !rd_oor_q) ? vram_rdata : '0;

  // Display pipeline: capture slot data one cycle after the RAM returns it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_d1   <= 1'b0;
      don_d1    <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      disp_d1   <= (owner_c == SLOT_DISP);
      don_d1    <= display_on;
      pix_valid <= don_d1;
      if (!don_d1) begin
        pix_data <= '0;
      end else if (disp_d1) begin
        pix_data <= vram_rdata;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  // Saturating count of cycles each master waited with a pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      if (m0_req && !m0_gnt && (m0_stall_cnt != 16'hFFFF)) begin
        m0_stall_cnt <= m0_stall_cnt + 16'd1;
      end
      if (m1_req && !m1_gnt && (m1_stall_cnt != 16'hFFFF)) begin
        m1_stall_cnt <= m1_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        display_on;
  logic [9:0]  x_pos, y_pos;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [14:0] m0_addr;
  logic [7:0]  m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [14:0] m1_addr;
  logic [7:0]  m1_wdata, m1_rdata;
  logic [14:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata, vram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] m0_stall_cnt, m1_stall_cnt;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] mem [0:32767];

  vram_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .display_on (display_on),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .m0_req     (m0_req),
    .m0_we      (m0_we),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_gnt     (m0_gnt),
    .m0_rvalid  (m0_rvalid),
    .m0_rdata   (m0_rdata),
    .m1_req     (m1_req),
    .m1_we      (m1_we),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_gnt     (m1_gnt),
    .m1_rvalid  (m1_rvalid),
    .m1_rdata   (m1_rdata),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .m0_stall_cnt (m0_stall_cnt),
    .m1_stall_cnt (m1_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input logic [14:0] a);
    case (a)
      15'd323:   init_val = 8'h3C;
      15'd50:    init_val = 8'h77;
      15'd51:    init_val = 8'h88;
      15'd19200: init_val = 8'hFF;
      default:   init_val = 8'h00;
    endcase
  endfunction

  // RAM model: preloaded on reset, write-first-cycle, registered read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32768; i++) mem[i] <= init_val(15'(i));
      vram_rdata <= 8'h00;
    end else begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      vram_rdata <= mem[vram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    display_on = 1'b0; x_pos = '0; y_pos = '0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {pix_data, pix_valid, m0_gnt, m0_rvalid, m0_rdata,
                   m1_gnt, m1_rvalid, m1_rdata, vram_addr, vram_we, vram_wdata}, 64'd0);
  endtask

  logic [3:0] rr_m0_gnt = 4'b0101;  // bit k = cycle k
  logic [3:0] rr_m1_gnt = 4'b1010;
  logic [3:0] rr_m0_rv  = 4'b1010;
  logic [3:0] rr_m1_rv  = 4'b0100;

  initial begin
    // reset with busy inputs: every output must be held at 0
    rst_n = 1'b0;
    display_on = 1'b1; x_pos = 10'd12; y_pos = 10'd8;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 15'd100; m0_wdata = 8'hA5;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'd5;   m1_wdata = 8'h00;
    tick; tick; settle;
    check_all_zero("reset_outputs");

    tick; idle_inputs(); rst_n = 1'b1;

    // display slot at texel (3,2)
    tick; display_on = 1'b1; x_pos = 10'd12; y_pos = 10'd8;
    settle;
    check_eq("disp_addr", 64'(vram_addr), 64'd323);
    check_eq("disp_we", 64'(vram_we), 64'd0);
    tick; x_pos = 10'd13;
    settle;
    check_eq("idle_addr_hold", 64'(vram_addr), 64'd323);
    check_eq("pix_valid_lat1", 64'(pix_valid), 64'd0);
    tick; x_pos = 10'd14;
    settle;
    check_eq("pix_valid_lat2", 64'(pix_valid), 64'd1);
    check_eq("pix_data_lat2", 64'(pix_data), 64'h3C);
    tick; x_pos = 10'd15;
    settle;
    check_eq("pix_data_hold", 64'(pix_data), 64'h3C);
    tick; idle_inputs();
    tick; tick; settle;
    check_eq("pix_valid_off", 64'(pix_valid), 64'd0);
    check_eq("pix_data_off", 64'(pix_data), 64'd0);

    // both masters reading in blanking: strict alternation, m0 first
    tick;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'd50;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'd51;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick;
      settle;
      check_eq($sformatf("rr_m0_gnt%0d", k), 64'(m0_gnt), 64'(rr_m0_gnt[k]));
      check_eq($sformatf("rr_m1_gnt%0d", k), 64'(m1_gnt), 64'(rr_m1_gnt[k]));
      check_eq($sformatf("rr_m0_rv%0d", k), 64'(m0_rvalid), 64'(rr_m0_rv[k]));
      check_eq($sformatf("rr_m1_rv%0d", k), 64'(m1_rvalid), 64'(rr_m1_rv[k]));
      if (k == 1) check_eq("rr_m0_rdata", 64'(m0_rdata), 64'h77);
      if (k == 2) check_eq("rr_m1_rdata", 64'(m1_rdata), 64'h88);
    end
    tick; idle_inputs();
    settle;
    check_eq("rr_last_rv", 64'(m1_rvalid), 64'd1);
    check_eq("rr_last_rdata", 64'(m1_rdata), 64'h88);

    // m0 write colliding with a display slot
    tick;
    display_on = 1'b1; x_pos = 10'd16; y_pos = 10'd0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 15'd100; m0_wdata = 8'hA5;
    settle;
    check_eq("wr_blocked_gnt", 64'(m0_gnt), 64'd0);
    check_eq("wr_blocked_we", 64'(vram_we), 64'd0);
    check_eq("wr_blocked_addr", 64'(vram_addr), 64'd4);
    tick; x_pos = 10'd17;
    settle;
    check_eq("wr_gnt", 64'(m0_gnt), 64'd1);
    check_eq("wr_port", {vram_we, vram_addr, vram_wdata}, {1'b1, 15'd100, 8'hA5});
    tick; idle_inputs();
    settle;
    check_eq("wr_no_rvalid", 64'(m0_rvalid), 64'd0);
    check_eq("wr_idle_port", {vram_we, vram_addr, vram_wdata}, {1'b0, 15'd100, 8'hA5});
    check_eq("wr_ram", 64'(mem[100]), 64'hA5);

    // out-of-range read then back-to-back out-of-range write from m1
    tick; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'd19200;
    settle;
    check_eq("oor_rd_gnt", 64'(m1_gnt), 64'd1);
    check_eq("oor_rd_we", 64'(vram_we), 64'd0);
    tick; m1_we = 1'b1; m1_wdata = 8'h11;
    settle;
    check_eq("oor_rd_rv", 64'(m1_rvalid), 64'd1);
    check_eq("oor_rd_data", 64'(m1_rdata), 64'd0);
    check_eq("oor_wr_gnt", 64'(m1_gnt), 64'd1);
    check_eq("oor_wr_we", 64'(vram_we), 64'd0);
    tick; idle_inputs();
    settle;
    check_eq("oor_wr_no_rv", 64'(m1_rvalid), 64'd0);
    check_eq("oor_wr_ram", 64'(mem[19200]), 64'hFF);

    // reset lands with an m0 read in flight
    tick; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 15'd50;
    settle;
    check_eq("flight_gnt", 64'(m0_gnt), 64'd1);
    tick; m0_req = 1'b0; rst_n = 1'b0;
    settle;
    check_eq("flight_rv_reset", 64'(m0_rvalid), 64'd0);
    check_all_zero("flight_outputs");
    tick; rst_n = 1'b1;
    tick; settle;
    check_eq("flight_rv_after", 64'(m0_rvalid), 64'd0);

    // last grant before reset was m0, so m0 first again proves the pointer cleared
    tick; m0_req = 1'b1; m1_req = 1'b1;
    settle;
    check_eq("rr_reset_m0", 64'(m0_gnt), 64'd1);
    check_eq("rr_reset_m1", 64'(m1_gnt), 64'd0);
    tick; idle_inputs();

`ifdef VRAM_ARB_STATS_EN
    tick; rst_n = 1'b0;
    tick; rst_n = 1'b1;
    tick; display_on = 1'b1; y_pos = 10'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 15'd60;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) tick;
      x_pos = 10'(s * 4);
      settle;
      check_eq($sformatf("stall_gnt%0d", s), 64'(m1_gnt), 64'd0);
    end
    tick; x_pos = 10'd21;
    settle;
    check_eq("stall_release", 64'(m1_gnt), 64'd1);
    tick; idle_inputs();
    settle;
    check_eq("m1_stall_cnt", 64'(m1_stall_cnt), 64'd5);
    check_eq("m0_stall_cnt", 64'(m0_stall_cnt), 64'd0);
`endif

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
